// File: rtl/mem_responder.sv
// Word RAM plus MMIO window (console FIFO, cycle, halt, overflow) opposite the core.
// Define MEM_RESPONDER_MISALIGN_TRAP_EN to trap accesses with addr[1:0] != 0.
module mem_responder #(
  parameter int          MEM_WORDS  = 4096,
  parameter              INIT_FILE  = "",
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready,
  output logic        halt,
  output logic [7:0]  exit_code,
  output logic        misalign_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [FW:0] FULL_CNT = (FW+1)'(FIFO_DEPTH);

  logic [31:0]   mem [MEM_WORDS];
  logic [7:0]    fifo [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr;
  logic [FW-1:0] wr_ptr;
  logic [FW:0]   count;
  logic [31:0]   cycle_cnt;
  logic [31:0]   ovf_cnt;
  logic [31:0]   ram_q;
  logic [31:0]   mmio_q;
  logic          sel_ram;

  logic          is_mmio;
  logic [31:0]   off;
  logic [1:0]    reg_sel;
  logic [AW-1:0] idx;
  logic          mis;
  logic          wr_ok;
  logic          ram_we;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          accept;
  logic          drop;
  logic [31:0]   mmio_rd;
  logic          unused_ok;

  assign is_mmio = addr >= MMIO_BASE;
  assign off     = addr - MMIO_BASE;
  assign reg_sel = off[3:2];
  assign idx     = addr[AW+1:2];

`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
  assign mis = |addr[1:0];
`else
  assign mis = 1'b0;
`endif

  assign unused_ok = &{1'b0, off[31:4], off[1:0]};

  assign wr_ok  = we && !halt && !mis;
  assign ram_we = resetn && wr_ok && !is_mmio;
  assign push   = wr_ok && is_mmio && (reg_sel == 2'd0);
  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign pop    = !empty && console_ready;
  // a pop frees the slot this push lands in, so a full FIFO can still accept
  assign accept = push && (!full || pop);
  assign drop   = push && full && !pop;

  assign console_valid = !empty;
  assign console_data  = fifo[rd_ptr];
  assign rdata         = sel_ram ? ram_q : mmio_q;

  always_comb begin
    mmio_rd = '0;
    unique case (reg_sel)
      2'd0: mmio_rd = {16'b0, 8'(count), 6'b0, empty, full};
      2'd1: mmio_rd = cycle_cnt;
      2'd2: mmio_rd = {23'b0, halt, exit_code};
      2'd3: mmio_rd = ovf_cnt;
    endcase
  end

  // read-first: ram_q captures the word before this edge's write lands
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= wdata;
    ram_q <= mem[idx];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      cycle_cnt    <= '0;
      ovf_cnt      <= '0;
      mmio_q       <= '0;
      sel_ram      <= 1'b0;
      halt         <= 1'b0;
      exit_code    <= '0;
      misalign_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo[i] <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      sel_ram   <= !is_mmio && !mis;
      mmio_q    <= mis ? 32'hDEAD_BEEF : mmio_rd;
      if (accept) begin
        fifo[wr_ptr] <= wdata[7:0];
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FW{1'b0}}, accept}
                     - {{FW{1'b0}}, pop};
      if (drop && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 32'd1;
      if (wr_ok && is_mmio && reg_sel == 2'd3) ovf_cnt <= '0;
      if (wr_ok && is_mmio && reg_sel == 2'd2) begin
        halt      <= 1'b1;
        exit_code <= wdata[7:0];
      end
      if (mis) misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed plus randomized bench for mem_responder against a queue/array model.
// Honours MEM_RESPONDER_MISALIGN_TRAP_EN in the same way as the design.
module tb_mem_responder;

  localparam int          MW   = 256;
  localparam int          FD   = 8;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        console_valid;
  logic [7:0]  console_data;
  logic        console_ready;
  logic        halt;
  logic [7:0]  exit_code;
  logic        misalign_err;

  mem_responder #(
    .MEM_WORDS(MW), .INIT_FILE(""),
    .MMIO_BASE(BASE), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .addr(addr), .wdata(wdata), .we(we),
    .rdata(rdata),
    .console_valid(console_valid),
    .console_data(console_data),
    .console_ready(console_ready),
    .halt(halt), .exit_code(exit_code),
    .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] m_mem [MW];
  bit          m_known [MW];
  logic [7:0]  m_q [$];
  logic [31:0] m_cyc;
  logic [31:0] m_ovf;
  logic        m_halt;
  logic [7:0]  m_exit;
  logic        m_mis;
  logic [31:0] m_rdata;
  bit          m_rd_known;

  int total;
  int passed;
  int fails;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic [31:0] a,
                            input logic [31:0] d,
                            input logic w,
                            input logic r,
                            input logic rn);
    logic [31:0] o;
    int sel;
    int idx;
    int n;
    bit is_m;
    bit mis_now;
    bit pop;
    if (!rn) begin
      m_q.delete();
      m_cyc = 0; m_ovf = 0;
      m_halt = 0; m_exit = 0; m_mis = 0;
      m_rdata = 0; m_rd_known = 1;
      return;
    end
    mis_now = TRAP && (a % 4 != 0);
    is_m = (a >= BASE);
    o = a - BASE;
    sel = int'((o % 16) / 4);
    idx = int'((a / 4) % MW);
    n = m_q.size();
    m_rd_known = 1;
    if (mis_now) m_rdata = 32'hDEAD_BEEF;
    else if (is_m) begin
      case (sel)
        0: m_rdata = {16'b0, 8'(n), 6'b0, n == 0, n == FD};
        1: m_rdata = m_cyc;
        2: m_rdata = {23'b0, m_halt, m_exit};
        default: m_rdata = m_ovf;
      endcase
    end else begin
      m_rdata = m_mem[idx];
      m_rd_known = m_known[idx];
    end
    pop = (n > 0) && r;
    if (pop) void'(m_q.pop_front());
    if (w && !m_halt && !mis_now) begin
      if (!is_m) begin
        m_mem[idx] = d;
        m_known[idx] = 1;
      end else begin
        case (sel)
          0: begin
            if (n < FD || pop) m_q.push_back(d[7:0]);
            else if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
          end
          2: begin
            m_halt = 1;
            m_exit = d[7:0];
          end
          3: m_ovf = 0;
          default: ;
        endcase
      end
    end
    m_cyc++;
    if (mis_now) m_mis = 1;
  endtask

  task automatic step(input logic [31:0] a,
                      input logic [31:0] d,
                      input logic w,
                      input logic r,
                      input logic rn);
    addr = a; wdata = d; we = w;
    console_ready = r; resetn = rn;
    @(posedge clk);
    model_edge(a, d, w, r, rn);
    #1;
    if (m_rd_known) chk("rdata", rdata, m_rdata);
    chk("console_valid", {31'b0, console_valid},
        {31'b0, m_q.size() != 0});
    if (m_q.size() != 0)
      chk("console_data", {24'b0, console_data}, {24'b0, m_q[0]});
    chk("halt", {31'b0, halt}, {31'b0, m_halt});
    chk("exit_code", {24'b0, exit_code}, {24'b0, m_exit});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
  endtask

  logic [31:0] w40;
  logic [31:0] c0;
  logic [31:0] a;
  int          k;

  initial begin
    total = 0; passed = 0; fails = 0;
    addr = 0; wdata = 0; we = 0;
    console_ready = 0; resetn = 0;

    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_valid", {31'b0, console_valid}, 32'h0);
    chk("reset_halt", {31'b0, halt}, 32'h0);

    for (int i = 0; i < MW; i++) step(i * 4, $urandom, 1, 0, 1);
    w40 = m_mem[16];

    // RAM write/read, aliasing
    step(32'h10, 32'h1234_5678, 1, 0, 1);
    step(32'h10, 0, 0, 0, 1);
    chk("ram_rd", rdata, 32'h1234_5678);
    step(32'h10 + 4 * MW, 0, 0, 0, 1);
    chk("ram_alias", rdata, 32'h1234_5678);

    // read-first collision
    step(32'h20, 32'hAAAA_AAAA, 1, 0, 1);
    step(32'h20, 32'h5555_5555, 1, 0, 1);
    chk("rd_first_old", rdata, 32'hAAAA_AAAA);
    step(32'h20, 0, 0, 0, 1);
    chk("rd_first_new", rdata, 32'h5555_5555);

    // console: 9 pushes into 8 slots
    for (int i = 0; i < 9; i++) step(BASE, 32'h41 + i, 1, 0, 1);
    step(BASE, 0, 0, 0, 1);
    chk("con_status_full", rdata, 32'h0000_0801);
    step(BASE + 32'hC, 0, 0, 0, 1);
    chk("ovf_one", rdata, 32'h1);
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", {24'b0, console_data}, 32'h41 + i);
      step(32'h100, 0, 0, 1, 1);
    end
    chk("drain_empty", {31'b0, console_valid}, 32'h0);

    // full FIFO push coinciding with a pop
    for (int i = 0; i < 8; i++) step(BASE, 32'h61 + i, 1, 0, 1);
    step(BASE, 32'h7A, 1, 1, 1);
    step(BASE, 0, 0, 0, 1);
    chk("push_pop_full", rdata, 32'h0000_0801);
    step(BASE + 32'hC, 0, 0, 0, 1);
    chk("ovf_unchanged", rdata, 32'h1);
    for (int i = 0; i < 10; i++) step(32'h100, 0, 0, 1, 1);
    step(BASE + 32'hC, 0, 1, 0, 1);
    step(BASE + 32'hC, 0, 0, 0, 1);
    chk("ovf_clear", rdata, 32'h0);

    // randomized traffic, no halt writes
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      if (k < 5) begin
        a = ($urandom & 32'h7FFF_FC00)
          | (32'($urandom_range(64, MW - 1)) << 2);
        step(a, $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1);
      end else begin
        k = $urandom_range(0, 3);
        a = BASE | ($urandom & 32'h0FFF_FFF0) | (32'(k) << 2);
        step(a, $urandom,
             (k != 2) && ($urandom_range(0, 2) != 0),
             1'($urandom_range(0, 3) == 0), 1);
      end
    end
    for (int i = 0; i < 10; i++) step(32'h100, 0, 0, 1, 1);

    // halt
    step(BASE + 32'h8, 32'h2A, 1, 0, 1);
    chk("halt_set", {31'b0, halt}, 32'h1);
    chk("exit_code_set", {24'b0, exit_code}, 32'h2A);
    step(32'h40, ~w40, 1, 0, 1);
    step(32'h40, 0, 0, 0, 1);
    chk("halt_ram_wr_blocked", rdata, w40);
    step(BASE + 32'h8, 32'h55, 1, 0, 1);
    chk("halt_rewrite_blocked", {24'b0, exit_code}, 32'h2A);
    step(BASE + 32'h4, 0, 0, 0, 1);
    c0 = rdata;
    step(BASE + 32'h4, 0, 0, 0, 1);
    chk("cycle_delta", rdata - c0, 32'h1);

    // reset mid-drain
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(BASE, 32'h31 + i, 1, 0, 1);
    step(32'h100, 0, 0, 1, 1);
    step(BASE, 32'h39, 1, 1, 0);
    chk("rst_valid", {31'b0, console_valid}, 32'h0);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    step(BASE + 32'h4, 0, 0, 0, 1);
    chk("rst_cycle_small", {31'b0, rdata <= 32'd2}, 32'h1);
    step(BASE + 32'hC, 0, 0, 0, 1);
    chk("rst_ovf", rdata, 32'h0);
    step(32'h10, 0, 0, 0, 1);
    chk("rst_ram_kept", rdata, 32'h1234_5678);

    // misaligned accesses
`ifdef MEM_RESPONDER_MISALIGN_TRAP_EN
    step(32'h41, 32'h0BAD_0BAD, 1, 0, 1);
    chk("mis_flag", {31'b0, misalign_err}, 32'h1);
    step(32'h40, 0, 0, 0, 1);
    chk("mis_wr_blocked", rdata, w40);
    step(32'h42, 0, 0, 0, 1);
    chk("mis_rd_beef", rdata, 32'hDEAD_BEEF);
`else
    step(32'h42, 0, 0, 0, 1);
    chk("mis_rd_ignored", rdata, w40);
    step(32'h41, 32'h0BAD_0BAD, 1, 0, 1);
    chk("mis_flag_zero", {31'b0, misalign_err}, 32'h0);
    step(32'h40, 0, 0, 0, 1);
    chk("mis_wr_ignored_bits", rdata, 32'h0BAD_0BAD);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
